// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: buffers aligned fetch words as halfwords and presents
// one 32-bit or compressed instruction per handshake, each tagged with its PC.
module fetch_aligner #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH    = 4,
  parameter int          ENABLE_C = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               instr_compressed,
  output logic               instr_fault
);

  localparam int HW  = FETCH_W / 16;
  localparam int SKW = $clog2(HW);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [15:0]    buf_r [DEPTH];
  logic [PW-1:0]  rd_ptr_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [CW-1:0]  count_r;
  logic [31:0]    head_pc_r;
  logic [SKW-1:0] skip_r;
  logic           first_r;

  logic [15:0]    h0_s;
  logic [15:0]    h1_s;
  logic           is32_s;
  logic           avail_s;
  logic           fault_s;
  logic           fire_s;
  logic           deq_s;
  logic [CW-1:0]  wr_n_s;
  logic [CW-1:0]  rd_n_s;
  logic [CW-1:0]  count_nxt_s;
  logic [31:0]    flush_pc_s;

  // Decode the head of the buffer and derive handshakes and next occupancy.
  always_comb begin
    h0_s        = buf_r[rd_ptr_r];
    h1_s        = buf_r[rd_ptr_r + PW'(1)];
    is32_s      = (h0_s[1:0] == 2'b11) || (ENABLE_C == 0);
    avail_s     = is32_s ? (count_r >= CW'(2)) : (count_r >= CW'(1));
    // Without RVC, a non-11 opcode or a halfword-aligned start PC is illegal.
    fault_s     = (!is32_s && (h0_s == 16'h0000))
               || ((ENABLE_C == 0) && (h0_s[1:0] != 2'b11))
               || ((ENABLE_C == 0) && first_r && head_pc_r[1]);
    fetch_ready = (count_r <= CW'(DEPTH - HW));
    fire_s      = fetch_valid && fetch_ready && !flush;
    deq_s       = avail_s && instr_ready && !flush;
    wr_n_s      = CW'(HW) - CW'(skip_r);
    rd_n_s      = is32_s ? CW'(2) : CW'(1);
    count_nxt_s = count_r + (fire_s ? wr_n_s : CW'(0)) - (deq_s ? rd_n_s : CW'(0));
    flush_pc_s  = flush_pc & 32'hFFFF_FFFE;

    instr_valid      = avail_s;
    instr_pc         = head_pc_r;
    instr            = avail_s ? (is32_s ? {h1_s, h0_s} : {16'h0000, h0_s}) : 32'h0000_0000;
    instr_compressed = avail_s && (h0_s[1:0] != 2'b11);
    instr_fault      = avail_s && fault_s;
  end

  // Halfword storage: write halfwords skip..HW-1 of an accepted word in order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= 16'h0000;
      end
    end else if (fire_s) begin
      for (int i = 0; i < HW; i++) begin
        if (i >= int'(skip_r)) begin
          buf_r[wr_ptr_r + PW'(i) - PW'(skip_r)] <= fetch_data[16*i +: 16];
        end
      end
    end
  end

  // Pointers, occupancy, PC tracking and start-of-stream state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      head_pc_r <= {RESET_PC[31:1], 1'b0};
      skip_r    <= RESET_PC[SKW:1];
      first_r   <= 1'b1;
    end else if (flush) begin
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      head_pc_r <= flush_pc_s;
      skip_r    <= flush_pc_s[SKW:1];
      first_r   <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      if (fire_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(wr_n_s);
        skip_r   <= '0;
      end
      if (deq_s) begin
        rd_ptr_r  <= rd_ptr_r + PW'(rd_n_s);
        head_pc_r <= head_pc_r + (is32_s ? 32'd4 : 32'd2);
        first_r   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Sits between instruction fetch and the decoder.
- Takes naturally aligned FETCH_W-bit fetch words and buffers them as 16-bit halfwords.
- Emits one instruction per handshake: 32-bit, or compressed zero-extended to 32 bits, each with its own PC.
- Handles 32-bit instructions that straddle fetch words, redirects via flush, and generalises fetch width, buffer depth and compressed-ISA mode.

Parameters:
- FETCH_W, 32: fetch word width in bits. Legal values 32 or 64. HW = FETCH_W/16 halfwords per word.
- DEPTH, 4: halfword buffer entries. Power of two, at least 2*HW.
- ENABLE_C, 1: 1 = RVC supported; 0 = every instruction must be 32-bit.
- RESET_PC, 32'h0: PC of the first instruction after reset.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- fetch_valid  input  1  fetch_data is valid
- fetch_ready  output  1  aligner accepts fetch_data this cycle
- fetch_data  input  FETCH_W  aligned fetch word; halfword 0 at bits [15:0], lowest address
- flush  input  1  redirect; discard all buffered state
- flush_pc  input  32  new PC; bit 0 ignored
- instr_valid  output  1  instr, instr_pc, instr_compressed, instr_fault are valid
- instr_ready  input  1  consumer takes the instruction
- instr  output  32  instruction; compressed = {16'b0, hw}
- instr_pc  output  32  instruction address
- instr_compressed  output  1  instr[1:0] != 2'b11
- instr_fault  output  1  illegal-encoding or misalignment marker

Behaviour:
- Reset (async, resetn=0):
  - count=0, rd/wr pointers=0, head_pc=RESET_PC.
  - skip = RESET_PC[log2(FETCH_W/8)-1:1].
  - instr_valid=0, instr_fault=0, instr=0, instr_pc=RESET_PC.
  - fetch_ready=1 from the first cycle after release.
- fetch_ready = (DEPTH - count >= HW).
  - Uses count at cycle start; a dequeue in the same cycle does not free space early.
- Fetch handshake (fetch_valid && fetch_ready):
  - Writes halfwords skip..HW-1 of fetch_data in ascending order. Halfwords below skip are dropped.
  - skip then clears to 0.
  - count updates at the clock edge.
- Output side is combinational from buffer registers, so a word written at edge N can be presented in cycle N+1.
- Head halfword h0 and successor h1:
  - h0[1:0] != 11 and ENABLE_C=1: compressed. instr_valid when count>=1. Consumes 1 halfword; head_pc += 2.
  - h0[1:0] == 11: 32-bit. instr_valid only when count>=2. instr={h1,h0}. Consumes 2 halfwords; head_pc += 4.
  - ENABLE_C=0 and h0[1:0] != 11: treated as 32-bit (count>=2) with instr_fault=1.
- instr_fault also asserts for:
  - compressed h0 == 16'h0000;
  - the first instruction after reset/flush when ENABLE_C=0 and the start PC has bit 1 set.
- instr_pc = head_pc.
- A presented instruction and its outputs hold stable while instr_valid && !instr_ready.
- Enqueue and dequeue in the same cycle: count += written - consumed. Pointers wrap modulo DEPTH.
- flush has priority over everything in the same cycle:
  - count=0, instr_valid=0 next cycle, head_pc={flush_pc[31:1],1'b0}.
  - skip = flush_pc[log2(FETCH_W/8)-1:1].
  - Any fetch word offered in the flush cycle is discarded; no handshake is counted.
  - Any dequeue in the flush cycle does not occur.
- Empty: instr_valid=0.
  - A lone 32-bit lower half is held until its upper halfword arrives; no partial output.
- Full (count > DEPTH-HW): fetch_ready=0 until enough halfwords drain.
- Reset mid-operation: all state returns to reset values immediately; buffered instructions are lost.

Test Plan:
(FETCH_W=32, DEPTH=4, ENABLE_C=1, RESET_PC=0 unless noted)
- Pair of compressed: word 32'h45014081, instr_ready=1 -> 32'h00004081 @pc 0x0, then 32'h00004501 @pc 0x2; both instr_compressed=1, instr_fault=0.
- Straddle: words 32'h05134501 then 32'h00010000 -> 32'h00004501 @0x0; 32'h00000513 @0x2, compressed=0; 32'h00000001 @0x6.
- Backpressure: instr_ready=0, fetch_valid=1 continuously -> exactly 2 words accepted, then fetch_ready=0. Outputs stable. Raise instr_ready -> drain in order, fetch_ready returns.
- Flush: flush=1, flush_pc=0x102, then word 32'h45014081 -> only 32'h00004501 @pc 0x102. A word offered in the flush cycle never appears.
- Fault: word 32'h00000000 -> instr=0 @0x0 and @0x2, each with instr_fault=1. ENABLE_C=0, word 32'h00004081 -> instr_fault=1.
- Reset mid-stream: assert resetn=0 while count=3 -> instr_valid=0 immediately, fetch_ready=1 after release, next instr_pc=0x0.
